// File: rtl/fifo9_fcs_check.sv
// fifo9_fcs_check: drains the 9-bit rx FIFO, strips/checks the Ethernet FCS, emits payload with sof/eof/verdict and frame counters
module fifo9_fcs_check #(
  parameter logic [10:0] MinLen = 11'd64,
  parameter logic [10:0] MaxLen = 11'd1518
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [8:0]  dout,
  input  logic        empty,
  output logic        rd_en,
  output logic        rd_clk,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_good,
  output logic [31:0] good_cnt,
  output logic [31:0] bad_cnt
);
  typedef enum logic [1:0] {SYNC, IDLE, DATA} state_t;
  state_t state, state_nx;
  logic rv, verdict;
  logic [10:0] len, len_inc;
  logic [31:0] crc;
  logic [4:0][7:0] dl;
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = {1'b0, r[31:1]} ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction
  assign rd_en = ~empty & ~sys_rst;
  assign rd_clk = sys_clk;
  always_comb begin
    len_inc = &len ? len : len + 11'd1;
    verdict = (crc == 32'hDEBB20E3) && (len >= MinLen) && (len <= MaxLen);
    state_nx = !rv ? state : state == SYNC ? (dout[8] ? SYNC : IDLE) : dout[8] ? DATA : IDLE;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= SYNC;
    else state <= state_nx;
  end
  // dl[4] is the pending payload byte; dl[3:0] are the trailing FCS candidates
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rv <= 1'b0;
      o_valid <= 1'b0;
      o_sof <= 1'b0;
      o_eof <= 1'b0;
      o_good <= 1'b0;
      o_data <= 8'h0;
      good_cnt <= 32'h0;
      bad_cnt <= 32'h0;
      len <= 11'h0;
      crc <= 32'hFFFFFFFF;
      dl <= '0;
    end else begin
      rv <= rd_en;
      o_valid <= 1'b0;
      if (rv && state != SYNC) begin
        if (dout[8]) begin
          len <= state == IDLE ? 11'd1 : len_inc;
          crc <= crc_next(state == IDLE ? 32'hFFFFFFFF : crc, dout[7:0]);
          dl <= {dl[3:0], dout[7:0]};
          if (state == DATA && len_inc >= 11'd6) begin
            o_valid <= 1'b1;
            o_data <= dl[4];
            o_sof <= len_inc == 11'd6;
            o_eof <= 1'b0;
            o_good <= 1'b0;
          end
        end else if (state == DATA) begin
          if (len >= 11'd5) begin
            o_valid <= 1'b1;
            o_data <= dl[4];
            o_sof <= len == 11'd5;
            o_eof <= 1'b1;
            o_good <= verdict;
            good_cnt <= good_cnt + {31'h0, verdict};
            bad_cnt <= bad_cnt + {31'h0, ~verdict};
          end else bad_cnt <= bad_cnt + 32'h1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo9_fcs_check.sv
// tb_fifo9_fcs_check: directed frames through a FIFO model, checks payload stream, markers, verdicts and counters
module tb_fifo9_fcs_check;
  logic sys_clk = 1'b0, sys_rst = 1'b1, empty, rd_en, rd_clk, o_valid, o_sof, o_eof, o_good;
  logic [8:0] dout = 9'h0;
  logic [7:0] o_data;
  logic [31:0] good_cnt, bad_cnt;
  logic hold = 1'b1;
  logic [8:0] mem [4096];
  int wp = 0, rp = 0;
  logic [7:0] fb [2048];
  logic [7:0] cd [8192];
  logic cs [8192], ce [8192], cg [8192];
  int cap_n = 0, base = 0, n_run = 0, n_fail = 0, gc = 0, bc = 0;

  fifo9_fcs_check dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .dout(dout), .empty(empty), .rd_en(rd_en), .rd_clk(rd_clk),
    .o_data(o_data), .o_valid(o_valid), .o_sof(o_sof), .o_eof(o_eof), .o_good(o_good),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #5 sys_clk = ~sys_clk;
  assign empty = (wp == rp) | hold;

  always @(posedge sys_clk) if (rd_en) begin
    dout <= mem[rp % 4096];
    rp <= rp + 1;
  end

  always @(negedge sys_clk) if (o_valid) begin
    cd[cap_n % 8192] <= o_data;
    cs[cap_n % 8192] <= o_sof;
    ce[cap_n % 8192] <= o_eof;
    cg[cap_n % 8192] <= o_good;
    cap_n <= cap_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [8:0] w);
    mem[wp % 4096] = w;
    wp++;
  endtask

  task automatic push_bytes(input int from, input int to);
    for (int i = from; i < to; i++) push({1'b1, fb[i]});
  endtask

  // Ethernet FCS: complemented CRC-32 of the payload, sent least significant byte first
  task automatic make_frame(input int n, input bit corrupt);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n - 4; i++) begin
      fb[i] = 8'(i);
      c = c ^ {24'h0, fb[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    c = ~c;
    for (int j = 0; j < 4; j++) fb[n - 4 + j] = c[8*j +: 8];
    if (corrupt) fb[n - 1] = fb[n - 1] ^ 8'h01;
  endtask

  task automatic drain(input bit bub);
    int k;
    k = 0;
    hold = 1'b0;
    while (rp != wp && k < 8000) begin
      @(negedge sys_clk);
      if (bub) hold = ~hold;
      k++;
    end
    hold = 1'b1;
    repeat (4) @(negedge sys_clk);
    #2;
    if (k >= 8000) check("drain timeout", 32'(k), 32'd0);
  endtask

  task automatic expect_out(input string tag, input int n, input bit g);
    int m, e_d, e_f;
    m = cap_n - base;
    e_d = 0;
    e_f = 0;
    check({tag, " count"}, 32'(m), 32'(n));
    for (int i = 0; i < m && i < n; i++) begin
      if (cd[(base + i) % 8192] !== fb[i]) e_d++;
      if (cs[(base + i) % 8192] !== (i == 0)) e_f++;
      if (ce[(base + i) % 8192] !== (i == n - 1)) e_f++;
    end
    check({tag, " data errs"}, 32'(e_d), 32'd0);
    check({tag, " sof/eof errs"}, 32'(e_f), 32'd0);
    if (n > 0 && m >= n) check({tag, " good"}, {31'h0, cg[(base + n - 1) % 8192]}, {31'h0, g});
    check({tag, " good_cnt"}, good_cnt, 32'(gc));
    check({tag, " bad_cnt"}, bad_cnt, 32'(bc));
    base = cap_n;
  endtask

  initial begin
    push(9'h000);
    repeat (3) @(negedge sys_clk);
    hold = 1'b0;
    @(negedge sys_clk);
    check("rst rd_en", {31'h0, rd_en}, 32'h0);
    check("rst o_valid", {31'h0, o_valid}, 32'h0);
    check("rst flags", {29'h0, o_sof, o_eof, o_good}, 32'h0);
    check("rst o_data", {24'h0, o_data}, 32'h0);
    check("rst good_cnt", good_cnt, 32'h0);
    check("rst bad_cnt", bad_cnt, 32'h0);
    hold = 1'b1;
    sys_rst = 1'b0;

    make_frame(64, 0);
    push_bytes(0, 64); push(9'h000);
    drain(0); gc++;
    expect_out("valid64", 60, 1);

    make_frame(64, 1);
    push_bytes(0, 64); push(9'h000);
    drain(0); bc++;
    expect_out("badfcs", 60, 0);

    make_frame(4, 0);
    push_bytes(0, 4); push(9'h000);
    drain(0); bc++;
    expect_out("runt4", 0, 0);

    make_frame(5, 0);
    push_bytes(0, 5); push(9'h000);
    drain(0); bc++;
    expect_out("len5", 1, 0);

    make_frame(1519, 0);
    push_bytes(0, 1519); push(9'h000);
    drain(0); bc++;
    expect_out("giant1519", 1515, 0);

    make_frame(1518, 0);
    push_bytes(0, 1518); push(9'h000);
    drain(0); gc++;
    expect_out("max1518", 1514, 1);

    make_frame(64, 0);
    push_bytes(0, 64); push(9'h000);
    drain(1); gc++;
    expect_out("bubbles", 60, 1);

    push(9'h000); push_bytes(0, 20);
    drain(0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("midrst o_valid", {31'h0, o_valid}, 32'h0);
    check("midrst good_cnt", good_cnt, 32'h0);
    sys_rst = 1'b0;
    #2;
    base = cap_n;
    gc = 1;
    bc = 0;
    push_bytes(20, 64); push(9'h000);
    push_bytes(0, 64); push(9'h000);
    drain(0);
    expect_out("after_rst", 60, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo9_fcs_check.md
# fifo9_fcs_check

Receive-side stage directly downstream of the GMII-to-FIFO writer. Drains the 9-bit word FIFO (`{rxc, rxd[7:0]}`, SFD already removed, frames terminated by `rxc=0` gap words). Strips and checks the 4-byte Ethernet FCS, then emits payload bytes with start/end-of-frame markers, a per-frame good/bad verdict and running frame counters. Sits in the FIFO read-clock domain.

## Interface
- `MinLen`, 11'd64: minimum good frame length in bytes, FCS included.
- `MaxLen`, 11'd1518: maximum good frame length in bytes, FCS included.

- `sys_clk` in 1: single clock; FIFO read clock.
- `sys_rst` in 1: synchronous, active-high reset.
- `dout` in 9: FIFO read data; bit 8 = `rxc`, bits 7:0 = byte.
- `empty` in 1: FIFO empty.
- `rd_en` out 1: FIFO read enable.
- `rd_clk` out 1: tied to `sys_clk`.
- `o_data` out 8: payload byte.
- `o_valid` out 1: `o_data` valid this cycle. There is no backpressure; the consumer must accept every valid byte.
- `o_sof` out 1: first payload byte of a frame (qualified by `o_valid`).
- `o_eof` out 1: last payload byte of a frame (qualified by `o_valid`).
- `o_good` out 1: frame verdict; meaningful only with `o_valid & o_eof`.
- `good_cnt` out 32: count of good frames; wraps.
- `bad_cnt` out 32: count of bad frames; wraps.

## Operation
- `rd_en = ~empty & ~sys_rst`. The FIFO has one-cycle read latency: `rv` (registered `rd_en`) marks the cycle in which `dout` is valid. Only `rv` cycles advance any state.
- **States**
  - SYNC (entered on reset): discard words until an `rxc=0` word, then go to IDLE. This prevents a partial frame after a mid-frame reset from being treated as a new frame.
  - IDLE: an `rxc=0` word is ignored. An `rxc=1` word means frame start: load it as byte 1, set len=1, seed the CRC, go to DATA.
  - DATA: an `rxc=1` word is appended and len increments. An `rxc=0` word ends the frame; go to IDLE.
- **Delay line.** Five byte slots: one pending payload slot plus four FCS candidates.
  - On each appended byte where len (after increment) ≥ 6, the oldest byte is emitted with `o_eof=0`.
  - `o_sof=1` on the first emission of the frame.
- **Frame end.** When the gap word arrives:
  - If len ≥ 5: emit the pending slot byte with `o_eof=1`, `o_good` = verdict, and `o_sof=1` if it is also the first emission (len==5).
  - If len ≤ 4: emit nothing. The frame is counted bad.
- **CRC.**
  - CRC-32, reflected polynomial 0xEDB88320, LSB-first per byte, init 0xFFFFFFFF, computed over all bytes including the FCS, with no final inversion.
  - The FCS is correct iff the register equals 0xDEBB20E3 after the last byte.
- **Length.** 11-bit counter, saturating at 2047.
- **Verdict.** `o_good = crc_ok & (len >= MinLen) & (len <= MaxLen)`.
- **Counters.** Exactly one of `good_cnt` / `bad_cnt` increments per frame, including runts of length ≤ 4.
- Empty bubbles mid-frame stall the block with no state change. There is no timeout.

## Timing
- Outputs are registered. A byte appearing on `dout` in an `rv` cycle produces at most one emission on `o_*` in the next cycle.
- Payload byte k of a frame is emitted one cycle after the `rv` cycle carrying byte k+5, or the gap word if k is the last payload byte.
- `o_valid` is high for at most one cycle per `rv` cycle.
- Counters update in the same cycle as the `o_eof` emission, or one cycle after the gap word's `rv` cycle for frames with len ≤ 4.
- Back-to-back frames separated by a single gap word are fully supported. There is no dead cycle beyond the gap word itself.
- **Reset values:** `rd_en`=0, `o_valid`=0, `o_sof`=0, `o_eof`=0, `o_good`=0, `o_data`=0, `good_cnt`=0, `bad_cnt`=0, state=SYNC, len=0, CRC=0xFFFFFFFF.
- Reset asserted mid-frame takes effect at the next edge. No eof is emitted for the aborted frame and no counter changes.

## Test plan
- **Valid frame.** Gap word, then a 64-byte frame with correct FCS (60-byte payload 0x00..0x3B), then gap → 60 `o_valid` bytes 0x00..0x3B; `o_sof` on 0x00; `o_eof`=1, `o_good`=1 on 0x3B; `good_cnt`=1.
- **Bad FCS.** Same frame with the last FCS byte XOR 0x01 → identical 60 bytes; `o_good`=0 at eof; `bad_cnt`=1.
- **Runt and 5-byte frames.**
  - 4-byte frame → no `o_valid`; `bad_cnt`+1.
  - 5-byte frame → a single byte with `o_sof`=`o_eof`=1 and `o_good`=0 (len < 64).
- **Giant.** 1519-byte frame with correct FCS → 1515 bytes emitted, `o_good`=0; a 1518-byte frame → `o_good`=1.
- **Bubbles.** Valid 64-byte frame with `empty` toggled every other cycle → output byte stream and verdict identical to the first test; no extra `o_valid` pulses.
- **Mid-frame reset.** Reset after byte 20 of a frame, then the remaining 44 bytes, a gap, then a valid frame → nothing emitted for the remnant; the second frame is emitted good; `good_cnt`=1, `bad_cnt`=0.
